clk_async_reset: RTL and testbench
==================================

CLK_ASYNC_RESET -- requirements
Module: clk_async_reset

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of reset-deassertion synchronizer flops; legal range 2..4.
REQ-002 Parameter DIV, default 1: qout toggles once every DIV clock cycles; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; rst=0 resets the block.
REQ-005 qout  output  1  registered toggle output; frequency is clk/(2*DIV).

Function
REQ-006 The block SHALL contain one internal reset, rst_int_n: cleared asynchronously when rst falls, set only after SYNC_STAGES rising clk edges with rst=1.
REQ-007 The synchronizer SHALL be a shift chain of SYNC_STAGES flops: D of stage 0 tied to 1, all stages cleared asynchronously by rst=0, and rst_int_n taken from the last stage.
REQ-008 The divide counter SHALL be ceil(log2(DIV)) bits wide, with a minimum width of 1, and SHALL be cleared asynchronously by rst_int_n=0.
REQ-009 On each rising edge with rst_int_n=1, when the counter equals DIV-1: clear the counter to 0 and invert qout.
REQ-010 On each rising edge with rst_int_n=1, when the counter is below DIV-1: increment the counter by 1 and hold qout.
REQ-011 With DIV=1, qout SHALL toggle on every rising edge after rst_int_n is released.
REQ-012 The first qout toggle SHALL occur on the DIV-th rising edge after the edge that sets rst_int_n; with defaults, this is the 3rd rising edge after rst rises.
REQ-013 The counter SHALL wrap only via REQ-009 and SHALL never exceed DIV-1.
REQ-014 qout SHALL be driven directly by a flop, with no combinational path from rst or clk to qout except the asynchronous clear.
REQ-015 Before the first rst assertion, qout is undefined; the bench SHALL NOT check it.

Reset
REQ-016 While rst=0: qout=0, counter=0, and all synchronizer stages=0, independent of clk.
REQ-017 Assertion SHALL take effect immediately, not on a clock edge.
REQ-018 A reset pulse of any width, including one shorter than a clock period, SHALL fully reset the block.
REQ-019 Reset asserted mid-count or mid-toggle SHALL abandon the count; after release, counting restarts from 0 per REQ-012.
REQ-020 If rst deasserts coincident with a rising edge, release SHALL take at most one extra cycle; there SHALL be no glitch on qout.

Structure
REQ-021 Package clk_async_reset_pkg SHALL hold DEFAULT_SYNC_STAGES=2, DEFAULT_DIV=1, and a constant function that computes the counter width.
REQ-022 The synchronizer SHALL be a separate sub-module, rst_sync, with ports clk, rst, and rst_out_n, parameterized by SYNC_STAGES.
REQ-023 The top level SHALL instantiate rst_sync once and implement the counter and the qout flop.
REQ-024 Elaboration SHALL fail on an illegal SYNC_STAGES or DIV.

Verification
All scenarios use a 10 ns clock with rising edges at 5, 15, 25, ... ns.
REQ-025 Defaults; rst=1 at 0 ns, rst=0 at 10 ns -> qout=0 at 10 ns, before the 15 ns edge.
REQ-026 Defaults; rst=1 at 30 ns -> qout stays 0 at the 35 and 45 ns edges, is 1 after the 55 ns edge, 0 after 65 ns, then alternates every edge.
REQ-027 DIV=3; release as in REQ-026 -> qout rises after the 75 ns edge and falls after the 105 ns edge.
REQ-028 Defaults; qout toggling; rst=0 pulse of 2 ns at 72 ns -> qout=0 at 72 ns; next toggle to 1 after the 95 ns edge.
REQ-029 SYNC_STAGES=3; rst=1 at 30 ns -> first toggle after the 65 ns edge.
REQ-030 Defaults; rst held 0 for 20 edges -> qout constantly 0 with no glitch, confirmed by waveform check.

Source files
------------

// File: rtl/clk_async_reset_pkg.sv
// clk_async_reset_pkg: shared defaults and counter-width helper for clk_async_reset
package clk_async_reset_pkg;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_DIV = 1;
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction
endpackage

// File: rtl/rst_sync.sv
// rst_sync: async-assert, sync-deassert reset synchronizer
module rst_sync
  import clk_async_reset_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  output logic rst_out_n
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("rst_sync: SYNC_STAGES must be 2..4");
  end
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync_q <= '0;
    else sync_q <= sync_d;
  assign rst_out_n = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/clk_async_reset.sv
// clk_async_reset: clock divider producing qout = clk/(2*DIV) behind a synchronized reset
module clk_async_reset
  import clk_async_reset_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int DIV         = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic qout
);
  if (DIV < 1 || DIV > 65535) begin : g_bad_div
    $error("clk_async_reset: DIV must be 1..65535");
  end
  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  logic rst_int_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qout_q, qout_d, wrap;
  rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk      (clk),
    .rst      (rst),
    .rst_out_n(rst_int_n)
  );
  always_comb begin
    wrap   = cnt_q == CNT_MAX;
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    qout_d = qout_q ^ wrap;
  end
  // rst_int_n falls combinationally with rst, so this clear is immediate too
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      cnt_q  <= '0;
      qout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      qout_q <= qout_d;
    end
  assign qout = qout_q;
endmodule

// File: tb/tb_clk_async_reset.sv
// tb_clk_async_reset: directed checks of defaults, DIV=3 and SYNC_STAGES=3 variants
module tb_clk_async_reset;
  logic clk = 1'b0;
  logic rst_d, rst_v, rst_s;
  logic q_d, q_v, q_s;
  int checks = 0;
  int errors = 0;
  int glitches = 0;
  logic hold = 1'b0;
  always #5 clk = ~clk;
  clk_async_reset dut_d (.clk(clk), .rst(rst_d), .qout(q_d));
  clk_async_reset #(.DIV(3)) dut_v (.clk(clk), .rst(rst_v), .qout(q_v));
  clk_async_reset #(.SYNC_STAGES(3)) dut_s (.clk(clk), .rst(rst_s), .qout(q_s));
  always @(q_d) if (hold) glitches++;
  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  initial begin
    rst_d = 1'b1; rst_v = 1'b1; rst_s = 1'b1;
    #10 rst_d = 1'b0; rst_v = 1'b0; rst_s = 1'b0;
    #1 check("rst_d_t11", q_d, 1'b0); check("rst_v_t11", q_v, 1'b0); check("rst_s_t11", q_s, 1'b0);
    #19 rst_d = 1'b1; rst_v = 1'b1; rst_s = 1'b1;
    #6 check("d_t36", q_d, 1'b0); check("v_t36", q_v, 1'b0); check("s_t36", q_s, 1'b0);
    #10 check("d_t46", q_d, 1'b0); check("v_t46", q_v, 1'b0); check("s_t46", q_s, 1'b0);
    #10 check("d_t56", q_d, 1'b1); check("v_t56", q_v, 1'b0); check("s_t56", q_s, 1'b0);
    #10 check("d_t66", q_d, 1'b0); check("v_t66", q_v, 1'b0); check("s_t66", q_s, 1'b1);
    #6 rst_d = 1'b0;
    #1 check("d_pulse_t73", q_d, 1'b0);
    #1 rst_d = 1'b1;
    #2 check("d_t76", q_d, 1'b0); check("v_t76", q_v, 1'b1); check("s_t76", q_s, 1'b0);
    #10 check("d_t86", q_d, 1'b0); check("v_t86", q_v, 1'b1); check("s_t86", q_s, 1'b1);
    #10 check("d_t96", q_d, 1'b1); check("v_t96", q_v, 1'b1); check("s_t96", q_s, 1'b0);
    #10 check("d_t106", q_d, 1'b0); check("v_t106", q_v, 1'b0); check("s_t106", q_s, 1'b1);
    #10 check("d_t116", q_d, 1'b1);
    #2 rst_d = 1'b0;
    #1 check("d_async_t119", q_d, 1'b0);
    rst_d = 1'b1;
    #7 check("d_t126", q_d, 1'b0);
    #10 check("d_t136", q_d, 1'b0);
    #10 check("d_t146", q_d, 1'b1);
    rst_d = 1'b0;
    #1 check("d_hold_t147", q_d, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("d_hold_%0d", i), q_d, 1'b0);
    end
    hold = 1'b0;
    checks++;
    assert (glitches == 0) else begin
      errors++;
      $error("FAIL d_glitch observed %0d expected 0", glitches);
    end
    rst_d = 1'b1;
    #6 check("d_rel_1", q_d, 1'b0);
    #10 check("d_rel_2", q_d, 1'b0);
    #10 check("d_rel_3", q_d, 1'b1);
    #10 check("d_rel_4", q_d, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
